// File: rtl/addsub_arbiter_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter:
// FSM encoding, requester count and the round-robin pick helper.
package addsub_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // A lone valid requester always wins; the pointer only breaks ties.
  function automatic logic [ID_W-1:0] rr_pick(input logic v0, input logic v1,
                                              input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] pick;
    if (v0 && v1) begin
      pick = ptr;
    end else if (v0) begin
      pick = ID_W'(0);
    end else begin
      pick = ID_W'(1);
    end
    return pick;
  endfunction

endpackage

// File: rtl/addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry, overflow, sign and zero flags.
// On subtract, cf reports a borrow (a < b unsigned).
module addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cf,
  output logic             ovf,
  output logic             sf,
  output logic             zf
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   wide_s;

  // Two's-complement add of a and (b or ~b + 1), then derive the flags.
  always_comb begin
    b_eff_s = sub ? ~b : b;
    wide_s  = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub};
    sum     = wide_s[WIDTH-1:0];
    cf      = sub ? ~wide_s[WIDTH] : wide_s[WIDTH];
    ovf     = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (wide_s[WIDTH-1] != a[WIDTH-1]);
    sf      = wide_s[WIDTH-1];
    zf      = (wide_s[WIDTH-1:0] == {WIDTH{1'b0}});
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one addsub between two requesters;
// accept -> EXEC -> RESP gives a two-cycle accept-to-response latency.
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cf,
  output logic             rsp_ovf,
  output logic             rsp_sf,
  output logic             rsp_zf
);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [ID_W-1:0]   ptr_r;
  logic [ID_W-1:0]   win_s;
  logic              any_valid_s;
  logic              req0_ready_s;
  logic              req1_ready_s;
  logic              accept_s;

  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              sub_r;
  logic [ID_W-1:0]   id_r;

  logic [WIDTH-1:0]  sum_s;
  logic              cf_s;
  logic              ovf_s;
  logic              sf_s;
  logic              zf_s;

  logic              rsp_valid_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [WIDTH-1:0]  rsp_sum_r;
  logic              rsp_cf_r;
  logic              rsp_ovf_r;
  logic              rsp_sf_r;
  logic              rsp_zf_r;

  assign any_valid_s = req0_valid | req1_valid;
  assign win_s       = rr_pick(req0_valid, req1_valid, ptr_r);
  assign accept_s    = (req0_ready_s & req0_valid) | (req1_ready_s & req1_valid);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = accept_s ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: state_nxt_s = rsp_ready ? ST_IDLE : ST_RESP;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: grant only in IDLE, never while reset is asserted.
  always_comb begin
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    if (!rst && (state_r == ST_IDLE) && any_valid_s) begin
      if (win_s == ID_W'(0)) begin
        req0_ready_s = 1'b1;
      end else begin
        req1_ready_s = 1'b1;
      end
    end else begin
      req0_ready_s = 1'b0;
      req1_ready_s = 1'b0;
    end
  end

  // Latch the winner's operation and hand priority to the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      sub_r <= 1'b0;
      id_r  <= ID_W'(0);
      ptr_r <= ID_W'(0);
    end else if (accept_s) begin
      a_r   <= (win_s == ID_W'(0)) ? req0_a   : req1_a;
      b_r   <= (win_s == ID_W'(0)) ? req0_b   : req1_b;
      sub_r <= (win_s == ID_W'(0)) ? req0_sub : req1_sub;
      id_r  <= win_s;
      ptr_r <= (win_s == ID_W'(0)) ? ID_W'(1) : ID_W'(0);
    end else begin
      a_r   <= a_r;
      b_r   <= b_r;
      sub_r <= sub_r;
      id_r  <= id_r;
      ptr_r <= ptr_r;
    end
  end

  addsub #(WIDTH) u_addsub (
    .a   (a_r),
    .b   (b_r),
    .sub (sub_r),
    .sum (sum_s),
    .cf  (cf_s),
    .ovf (ovf_s),
    .sf  (sf_s),
    .zf  (zf_s)
  );

  // Response register: captured at the end of EXEC, held until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= ID_W'(0);
      rsp_sum_r   <= {WIDTH{1'b0}};
      rsp_cf_r    <= 1'b0;
      rsp_ovf_r   <= 1'b0;
      rsp_sf_r    <= 1'b0;
      rsp_zf_r    <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= id_r;
      rsp_sum_r   <= sum_s;
      rsp_cf_r    <= cf_s;
      rsp_ovf_r   <= ovf_s;
      rsp_sf_r    <= sf_s;
      rsp_zf_r    <= zf_s;
    end else if ((state_r == ST_RESP) && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign req0_ready = req0_ready_s;
  assign req1_ready = req1_ready_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_sum    = rsp_sum_r;
  assign rsp_cf     = rsp_cf_r;
  assign rsp_ovf    = rsp_ovf_r;
  assign rsp_sf     = rsp_sf_r;
  assign rsp_zf     = rsp_zf_r;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed vectors plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_addsub_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_sub, req1_sub;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_cf, rsp_ovf, rsp_sf, rsp_zf;

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cf(rsp_cf), .rsp_ovf(rsp_ovf), .rsp_sf(rsp_sf), .rsp_zf(rsp_zf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cf, ovf, sf, zf;
    logic         id;
  } res_t;

  // Reference arithmetic from plain integer maths: true signed result vs. range.
  function automatic res_t model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub, input logic id);
    res_t   r;
    longint ua, ub, sa, sb, st, smax, smin;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    if (!sub) begin
      r.sum = a + b;
      r.cf  = (ua + ub) > ((longint'(1) << W) - 1);
      st    = sa + sb;
    end else begin
      r.sum = a - b;
      r.cf  = (ua < ub);
      st    = sa - sb;
    end
    r.ovf = (st > smax) || (st < smin);
    r.sf  = r.sum[W-1];
    r.zf  = (r.sum == '0);
    r.id  = id;
    return r;
  endfunction

  // Model state: one operation in flight, edges since its accept, tie-break pointer.
  bit   m_pending = 1'b0;
  int   m_age     = 0;
  bit   m_ptr     = 1'b0;
  bit   m_fresh   = 1'b1;
  res_t m_res     = '0;
  bit   checking  = 1'b0;

  logic m_win, exp_r0, exp_r1, exp_valid;
  assign m_win     = (req0_valid && req1_valid) ? m_ptr : !req0_valid;
  assign exp_r0    = !rst && !m_pending && req0_valid && (!req1_valid || m_ptr == 1'b0);
  assign exp_r1    = !rst && !m_pending && req1_valid && (!req0_valid || m_ptr == 1'b1);
  assign exp_valid = m_pending && (m_age >= 1);

  always @(posedge clk) begin
    if (rst) begin
      m_pending <= 1'b0;
      m_ptr     <= 1'b0;
      m_fresh   <= 1'b1;
    end else if (!m_pending) begin
      if (req0_valid || req1_valid) begin
        m_pending <= 1'b1;
        m_age     <= 0;
        m_ptr     <= !m_win;
        m_res     <= m_win ? model_op(req1_a, req1_b, req1_sub, 1'b1)
                           : model_op(req0_a, req0_b, req0_sub, 1'b0);
      end
    end else if (m_age == 0) begin
      m_age   <= 1;
      m_fresh <= 1'b0;
    end else if (rsp_ready) begin
      m_pending <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("req0_ready", req0_ready, exp_r0);
      chk("req1_ready", req1_ready, exp_r1);
      chk("rsp_valid", rsp_valid, exp_valid);
      if (exp_valid) begin
        chk("rsp_id", rsp_id, m_res.id);
        chk("rsp_sum", rsp_sum, m_res.sum);
        chk("rsp_flags", {rsp_cf, rsp_ovf, rsp_sf, rsp_zf}, {m_res.cf, m_res.ovf, m_res.sf, m_res.zf});
      end else if (m_fresh) begin
        chk("rsp_reset_fields", {rsp_id, rsp_sum, rsp_cf, rsp_ovf, rsp_sf, rsp_zf}, '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Wait (bounded) until requester id is granted; leaves us just before the accept edge.
  task automatic wait_grant(input int id, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk({name, "_grant"}, got, 1'b1);
  endtask

  // Single operation with literal expectations; also pins the 2-cycle latency.
  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] exp_sum,
                        input logic [3:0] exp_flags, input string name);
    rsp_ready = 1'b1;
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end
    wait_grant(id, name);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk({name, "_exec_valid"}, rsp_valid, 1'b0);
    @(negedge clk);
    chk({name, "_valid"}, rsp_valid, 1'b1);
    chk({name, "_id"}, rsp_id, id[0]);
    chk({name, "_sum"}, rsp_sum, exp_sum);
    chk({name, "_flags"}, {rsp_cf, rsp_ovf, rsp_sf, rsp_zf}, exp_flags);
    tick();
  endtask

  int grants[$];
  int ids[$];

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    tick();
    req0_valid = 1'b1;
    @(negedge clk);
    chk("reset_ready0", req0_ready, 1'b0);
    chk("reset_valid", rsp_valid, 1'b0);
    chk("reset_fields", {rsp_id, rsp_sum, rsp_cf, rsp_ovf, rsp_sf, rsp_zf}, '0);
    tick();
    rst = 1'b0; req0_valid = 1'b0; checking = 1'b1;
    tick();

    run_op(0, 32'd16, 32'd12, 1'b0, 32'd28, 4'b0000, "single");
    run_op(1, 32'h7FFF_FFFF, 32'h2, 1'b0, 32'h8000_0001, 4'b0110, "ovf");
    run_op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 4'b1001, "carry_zero");
    run_op(0, 32'h16, 32'h17, 1'b1, 32'hFFFF_FFFF, 4'b1010, "sub");

    // Contention: both requesters valid continuously after a reset.
    rst = 1'b1; tick(); rst = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_sub = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp_valid) ids.push_back(int'(rsp_id));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("contention_grant_count", grants.size() >= 4, 1'b1);
    chk("contention_rsp_count", ids.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk("contention_grant_order", grants[i], i % 2);
      if (i < ids.size()) chk("contention_rsp_id", ids[i], i % 2);
    end
    repeat (4) tick();

    // Backpressure: response held for 5 cycles while req1 waits ungranted.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd50; req0_sub = 1'b0;
    wait_grant(0, "bp");
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
      tick();
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_sum", rsp_sum, 32'd150);
      chk("bp_no_ready", {req0_ready, req1_ready}, 2'b00);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", rsp_valid, 1'b1);
    tick();
    req1_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("bp_single_completion", rsp_valid, 1'b0);
      tick();
    end

    // Reset while in EXEC: result discarded, pointer back to requester 0.
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_sub = 1'b0;
    wait_grant(0, "midrst");
    tick();
    req0_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("midrst_no_rsp", rsp_valid, 1'b0);
      tick();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("midrst_ptr_ready0", req0_ready, 1'b1);
    chk("midrst_ptr_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();

    // Randomized traffic, including dropped valids, backpressure and resets.
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      req0_valid = $urandom_range(0, 1) == 1;
      req1_valid = $urandom_range(0, 1) == 1;
      req0_a = pick(); req0_b = pick(); req0_sub = $urandom_range(0, 1) == 1;
      req1_a = pick(); req1_b = pick(); req1_sub = $urandom_range(0, 1) == 1;
      rsp_ready  = $urandom_range(0, 3) != 0;
      tick();
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
